ads122c04_ain_averager: RTL

ADS122C04_AIN_AVERAGER -- requirements
Module: ads122c04_ain_averager

---
 rtl/ads122c04_pkg.sv | 19 +
 rtl/ads122c04_ain_averager_change_det.sv | 38 +++
 rtl/ads122c04_ain_averager.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ads122c04_pkg.sv
// ads122c04_pkg
// Shared definitions for the ADS122C04 per-channel averager: FSM state
// encoding, accumulator width and the default parameter values.
package ads122c04_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    ACCUM   = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  localparam int ACC_W            = 36;
  localparam int NCH              = 4;
  localparam int AVG_MAX_LOG2_DEF = 4;
  localparam int SETTLE_CYC_DEF   = 2;

endpackage

// File: rtl/ads122c04_ain_averager_change_det.sv
// ain_sel_change_det
// Brings the controller's asynchronous channel-sequencer field into the clk
// domain and flags each change. The channel whose conversion just finished
// is the value held before the change.
//   clk, rst   : clock, synchronous active-high reset
//   ain_sel    : asynchronous sequencer index (next channel to convert)
//   sel_event  : high while the synchronized index differs from its last value
//   done_ch    : completed channel (the previous synchronized index)
module ain_sel_change_det (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ain_sel,
  output logic       sel_event,
  output logic [1:0] done_ch
);

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] prev;

  // The previous-value register always tracks, so a change is seen for
  // exactly one cycle whether or not the averager consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev    <= '0;
    end else begin
      sync_p0 <= ain_sel;
      sync_p1 <= sync_p0;
      prev    <= sync_p1;
    end
  end

  assign sel_event = (sync_p1 != prev);
  assign done_ch   = prev;

endmodule

// File: rtl/ads122c04_ain_averager.sv
// ads122c04_ain_averager
// Per-channel 2^L averaging of ADS122C04 results. A change of the sequencer
// index marks the previous channel's conversion as complete; after a settle
// wait the 24-bit code is captured, sign-extended and accumulated, and every
// 2^L samples the channel's average is published with a one-cycle strobe.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_ain0..3           : raw results, 24-bit code in [23:0]
//   i_ain_sel           : asynchronous sequencer index
//   i_enable            : accept new samples
//   i_avg_log2          : requested averaging exponent
//   i_clear             : restart all averaging
//   o_avg0..3, o_valid  : averaged results and per-channel update strobe
//   o_sample_cnt        : accepted samples (wrapping)
//   o_drop_cnt          : lost channel events (saturating)
//   o_busy              : FSM not idle
module ads122c04_ain_averager
  import ads122c04_pkg::*;
#(
  parameter int AVG_MAX_LOG2 = AVG_MAX_LOG2_DEF,
  parameter int SETTLE_CYC   = SETTLE_CYC_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ain0,
  input  logic [31:0] i_ain1,
  input  logic [31:0] i_ain2,
  input  logic [31:0] i_ain3,
  input  logic [1:0]  i_ain_sel,
  input  logic        i_enable,
  input  logic [2:0]  i_avg_log2,
  input  logic        i_clear,
  output logic [31:0] o_avg0,
  output logic [31:0] o_avg1,
  output logic [31:0] o_avg2,
  output logic [31:0] o_avg3,
  output logic [3:0]  o_valid,
  output logic [31:0] o_sample_cnt,
  output logic [7:0]  o_drop_cnt,
  output logic        o_busy
);

  function automatic logic signed [ACC_W-1:0] sext24(input logic [23:0] x);
    return {{(ACC_W-24){x[23]}}, x};
  endfunction

  // Arithmetic shift keeps negative averages correct; the result is
  // truncated to the 32-bit output word.
  function automatic logic [31:0] avg_shift(input logic signed [ACC_W-1:0] a,
                                            input logic [2:0] sh);
    logic signed [ACC_W-1:0] t;
    t = a >>> sh;
    return t[31:0];
  endfunction

  function automatic logic [2:0] clamp_log2(input logic [2:0] req);
    return (int'(req) > AVG_MAX_LOG2) ? 3'(AVG_MAX_LOG2) : req;
  endfunction

  state_t      state, state_nxt;
  logic        sel_event;
  logic [1:0]  ev_ch;
  logic        take_ev;
  logic [1:0]  ch;
  logic        pend_vld;
  logic [1:0]  pend_ch;
  logic [7:0]  settle_cnt;
  logic [2:0]  l_eff;
  logic        enable_d;
  logic [4:0]  cnt_inc;
  logic [4:0]  target;
  logic [23:0] ain_mux;

  logic signed [ACC_W-1:0] acc [NCH];
  logic        [4:0]       cnt [NCH];
  logic signed [31:0]      avg [NCH];
  logic signed [ACC_W-1:0] samp_p0;

  logic [31:0] unused_ain_hi;
  assign unused_ain_hi = {i_ain0[31:24], i_ain1[31:24], i_ain2[31:24], i_ain3[31:24]};

  ain_sel_change_det u_change_det (
    .clk       (i_clk),
    .rst       (i_rst),
    .ain_sel   (i_ain_sel),
    .sel_event (sel_event),
    .done_ch   (ev_ch)
  );

  // Clear outranks a simultaneous event; disabled events are discarded.
  assign take_ev = sel_event & i_enable & ~i_clear;
  assign cnt_inc = cnt[ch] + 5'd1;
  assign target  = 5'd1 << l_eff;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (pend_vld || take_ev) state_nxt = SETTLE;
        SETTLE:  if (settle_cnt == 8'(SETTLE_CYC - 1)) state_nxt = CAPTURE;
        CAPTURE: state_nxt = ACCUM;
        ACCUM:   state_nxt = (cnt_inc == target) ? OUTPUT : IDLE;
        OUTPUT:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settle_cnt   <= '0;
      ch           <= '0;
      pend_vld     <= 1'b0;
      pend_ch      <= '0;
      l_eff        <= '0;
      enable_d     <= 1'b0;
      o_drop_cnt   <= '0;
      o_sample_cnt <= '0;
      o_valid      <= '0;
    end else begin
      enable_d <= i_enable;
      o_valid  <= '0;
      if (i_clear || (i_enable && !enable_d)) l_eff <= clamp_log2(i_avg_log2);
      settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;

      if (i_clear) begin
        pend_vld <= 1'b0;
      end else if (state == IDLE) begin
        // A pending event is serviced first; a fresh event in the same
        // cycle takes its place in the pending slot.
        if (pend_vld) begin
          ch       <= pend_ch;
          pend_vld <= take_ev;
          if (take_ev) pend_ch <= ev_ch;
        end else if (take_ev) begin
          ch <= ev_ch;
        end
      end else if (take_ev) begin
        pend_vld <= 1'b1;
        pend_ch  <= ev_ch;
        if (pend_vld && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
      end

      if (state == ACCUM && !i_clear)  o_sample_cnt <= o_sample_cnt + 32'd1;
      if (state == OUTPUT && !i_clear) o_valid[ch] <= 1'b1;
    end
  end

  always_comb begin
    unique case (ch)
      2'd0:    ain_mux = i_ain0[23:0];
      2'd1:    ain_mux = i_ain1[23:0];
      2'd2:    ain_mux = i_ain2[23:0];
      default: ain_mux = i_ain3[23:0];
    endcase
  end

  // Capture stage
  always_ff @(posedge i_clk) begin
    if (state == CAPTURE) samp_p0 <= sext24(ain_mux);
  end

  // Accumulate / publish stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NCH; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
        avg[k] <= '0;
      end
    end else if (i_clear) begin
      for (int k = 0; k < NCH; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
      end
    end else if (state == ACCUM) begin
      acc[ch] <= acc[ch] + samp_p0;
      cnt[ch] <= cnt_inc;
    end else if (state == OUTPUT) begin
      avg[ch] <= avg_shift(acc[ch], l_eff);
      acc[ch] <= '0;
      cnt[ch] <= '0;
    end
  end

  assign o_avg0 = avg[0];
  assign o_avg1 = avg[1];
  assign o_avg2 = avg[2];
  assign o_avg3 = avg[3];

endmodule
